mb32_booth8_prep: RTL and testbench

MB32_BOOTH8_PREP -- requirements
Module: mb32_booth8_prep

---
 rtl/mb32_booth8_prep.sv | 121 ++++++++++++
 tb/tb_mb32_booth8_prep.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb32_booth8_prep.sv
// Radix-8 Booth recoder front end: registers the operand pair, then emits per-group selects and 3*my.
// Latency: 2 cycles from input transfer to out_valid; sustains 1 operation per cycle.
// Backpressure: skid-free valid/ready pipeline; outputs hold while out_valid=1 and out_ready=0.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   upstream handshake for the operand pair mx (multiplier), my_in (multiplicand)
//   s, d, t, q, n       per-group one-hot |digit| = 1/2/3/4 selects and the negate flag
//   my, tmy             registered multiplicand and its sign-extended triple
//   out_valid/out_ready downstream handshake
//   op_cnt              wrapping count of completed output transfers
module mb32_booth8_prep #(
   parameter int WIDTH     = 32,
   parameter int GROUP_CNT = (WIDTH >> 2) + 3
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     mx,
   input  logic [WIDTH-1:0]     my_in,
   output logic [GROUP_CNT-1:0] s,
   output logic [GROUP_CNT-1:0] d,
   output logic [GROUP_CNT-1:0] t,
   output logic [GROUP_CNT-1:0] q,
   output logic [GROUP_CNT-1:0] n,
   output logic [WIDTH-1:0]     my,
   output logic [WIDTH+1:0]     tmy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [15:0]          op_cnt
);

   localparam int XW = 3 * GROUP_CNT;

   logic                 a_valid;
   logic                 b_valid;
   logic                 advance_a;
   logic [WIDTH-1:0]     a_mx;
   logic [WIDTH-1:0]     a_my;
   logic [XW:0]          xw;
   logic [GROUP_CNT-1:0] s_c, d_c, t_c, q_c, n_c;
   logic [WIDTH+1:0]     tmy_c;

   // Stage B can take new data whenever it is empty or being drained this cycle.
   assign advance_a = ~b_valid | out_ready;
   // Gating with RST keeps the upstream from seeing a ready while the pipeline is held in reset.
   assign in_ready  = RST & (~a_valid | advance_a);
   assign out_valid = b_valid;

   always_comb begin
      // Sign-extended multiplier with the implicit x[-1]=0 at bit 0, so group i's
      // window {x[3i+2], x[3i+1], x[3i], x[3i-1]} is simply xw[3i+3:3i].
      xw = {{(XW - WIDTH){a_mx[WIDTH-1]}}, a_mx, 1'b0};
      s_c = '0;
      d_c = '0;
      t_c = '0;
      q_c = '0;
      n_c = '0;
      for (int i = 0; i < GROUP_CNT; i++) begin
         case (xw[3*i +: 4])
            4'b0001, 4'b0010: s_c[i] = 1'b1;
            4'b0011, 4'b0100: d_c[i] = 1'b1;
            4'b0101, 4'b0110: t_c[i] = 1'b1;
            4'b0111:          q_c[i] = 1'b1;
            4'b1000:          begin q_c[i] = 1'b1; n_c[i] = 1'b1; end
            4'b1001, 4'b1010: begin t_c[i] = 1'b1; n_c[i] = 1'b1; end
            4'b1011, 4'b1100: begin d_c[i] = 1'b1; n_c[i] = 1'b1; end
            4'b1101, 4'b1110: begin s_c[i] = 1'b1; n_c[i] = 1'b1; end
            default:          ; // 0000 and 1111 are digit 0: everything stays clear
         endcase
      end
      // Two guard bits make 3*my exact for any WIDTH-bit two's complement my.
      tmy_c = {{2{a_my[WIDTH-1]}}, a_my} + {a_my[WIDTH-1], a_my, 1'b0};
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         a_valid <= 1'b0;
         a_mx    <= '0;
         a_my    <= '0;
         b_valid <= 1'b0;
         s       <= '0;
         d       <= '0;
         t       <= '0;
         q       <= '0;
         n       <= '0;
         my      <= '0;
         tmy     <= '0;
         op_cnt  <= '0;
      end else begin
         // Stage A
         if (in_valid && in_ready) begin
            a_valid <= 1'b1;
            a_mx    <= mx;
            a_my    <= my_in;
         end else if (advance_a) begin
            a_valid <= 1'b0;
         end

         // Stage B: data only moves on a real load so a stalled result never changes.
         if (advance_a) begin
            b_valid <= a_valid;
            if (a_valid) begin
               s   <= s_c;
               d   <= d_c;
               t   <= t_c;
               q   <= q_c;
               n   <= n_c;
               my  <= a_my;
               tmy <= tmy_c;
            end
         end

         if (b_valid && out_ready) begin
            op_cnt <= op_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_mb32_booth8_prep.sv
// Bench for mb32_booth8_prep: directed Booth cases, stall/ordering, mid-flight reset, random stream.
// Accepted operand pairs go into a scoreboard queue; each output transfer is checked against it.
// Expected selects come from the arithmetic digit formula, independent of the RTL decode table.
module tb_mb32_booth8_prep;

   logic        CLK;
   logic        RST;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] mx;
   logic [31:0] my_in;
   logic [10:0] s, d, t, q, n;
   logic [31:0] my;
   logic [33:0] tmy;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] op_cnt;

   mb32_booth8_prep #(.WIDTH(32), .GROUP_CNT(11)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mx        (mx),
      .my_in     (my_in),
      .s         (s),
      .d         (d),
      .t         (t),
      .q         (q),
      .n         (n),
      .my        (my),
      .tmy       (tmy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .op_cnt    (op_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] x;
      logic [31:0] y;
   } pair_t;

   pair_t       sb[$];
   pair_t       cur;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] cnt_model = '0;
   logic        in_fire_s = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Expected {s,d,t,q,n} from digit = -4*x[3g+2] + 2*x[3g+1] + x[3g] + x[3g-1].
   function automatic logic [54:0] model_sel(input logic [31:0] x);
      logic [10:0] es, ed, et, eq, en;
      logic [32:0] xe;
      int dig, mag, bm;
      es = '0; ed = '0; et = '0; eq = '0; en = '0;
      xe = {x[31], x};
      for (int g = 0; g < 11; g++) begin
         if (g > 0) bm = int'(xe[3*g-1]);
         else       bm = 0;
         dig = -4 * int'(xe[3*g+2]) + 2 * int'(xe[3*g+1]) + int'(xe[3*g]) + bm;
         mag = (dig < 0) ? -dig : dig;
         es[g] = (mag == 1);
         ed[g] = (mag == 2);
         et[g] = (mag == 3);
         eq[g] = (mag == 4);
         en[g] = (dig < 0);
      end
      return {es, ed, et, eq, en};
   endfunction

   // Rebuild sum_i digit_i * 8^i from the DUT's select outputs.
   function automatic longint recon(input logic [10:0] vs, vd, vt, vq, vn);
      longint sum;
      int mag;
      sum = 0;
      for (int g = 0; g < 11; g++) begin
         mag = vs[g] ? 1 : vd[g] ? 2 : vt[g] ? 3 : vq[g] ? 4 : 0;
         if (vn[g]) mag = -mag;
         sum += longint'(mag) * (longint'(1) << (3 * g));
      end
      return sum;
   endfunction

   // Monitor: both handshakes sampled on the falling edge, mid-cycle.
   always @(negedge CLK) begin
      longint t3;
      if (!RST) begin
         sb.delete();
         cnt_model = '0;
         in_fire_s = 1'b0;
      end else begin
         in_fire_s = in_valid && in_ready;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("stale_out", 1, 0);
            end else begin
               cur = sb.pop_front();
               t3 = 3 * longint'($signed(cur.y));
               chk("sel",   {9'b0, s, d, t, q, n}, {9'b0, model_sel(cur.x)});
               chk("my",    my, cur.y);
               chk("tmy",   tmy, t3[33:0]);
               chk("recon", recon(s, d, t, q, n), longint'($signed(cur.x)));
            end
            chk("op_cnt", op_cnt, cnt_model);
            cnt_model = cnt_model + 16'd1;
         end
         if (in_fire_s) sb.push_back('{x: mx, y: my_in});
      end
   end

   task automatic directed(input logic [31:0] x, input logic [31:0] y,
                           input logic [10:0] es, input logic [10:0] ed, input logic [10:0] et,
                           input logic [10:0] eq, input logic [10:0] en,
                           input logic [33:0] etmy, input string tag);
      @(posedge CLK); #1;
      in_valid  = 1'b1;
      mx        = x;
      my_in     = y;
      out_ready = 1'b1;
      chk({tag, "_in_ready"}, in_ready, 1);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      chk({tag, "_lat1"}, out_valid, 0);
      @(posedge CLK); #1;
      chk({tag, "_lat2"}, out_valid, 1);
      chk({tag, "_sel"}, {9'b0, s, d, t, q, n}, {9'b0, es, ed, et, eq, en});
      chk({tag, "_my"},  my, y);
      chk({tag, "_tmy"}, tmy, etmy);
      @(posedge CLK); #1;
   endtask

   task automatic drain(input string tag);
      int g;
      g = 0;
      out_ready = 1'b1;
      while ((sb.size() != 0 || out_valid) && g < 40) begin
         @(posedge CLK); #1;
         g++;
      end
      chk(tag, sb.size(), 0);
   endtask

   task automatic pulse_reset();
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
   endtask

   logic [31:0] corner [4];
   logic [31:0] stall_x [4];
   logic [54:0] sel_h;
   logic [31:0] my_h;
   logic [33:0] tmy_h;

   function automatic logic [31:0] pick();
      if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
      return $urandom;
   endfunction

   initial begin
      int n_acc;
      int cyc;
      corner  = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
      stall_x = '{32'h1234_5678, 32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'h8000_0000};
      RST = 1'b0; in_valid = 1'b0; mx = '0; my_in = '0; out_ready = 1'b0;

      // Reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready",  in_ready, 0);
      chk("rst_sel",       {9'b0, s, d, t, q, n}, 0);
      chk("rst_my",        my, 0);
      chk("rst_tmy",       tmy, 0);
      chk("rst_op_cnt",    op_cnt, 0);
      @(negedge CLK);
      RST = 1'b1;
      #1;
      chk("in_ready_after_rst", in_ready, 1);

      // Directed encodings
      directed(32'd1, 32'd5, 11'h001, 11'h000, 11'h000, 11'h000, 11'h000, 34'd15, "d1");
      chk("d1_op_cnt", op_cnt, 1);
      directed(32'hFFFF_FFFF, 32'hFFFF_FFFE, 11'h001, 11'h000, 11'h000, 11'h000, 11'h001,
               34'h3_FFFF_FFFA, "dm1");
      directed(32'd4, 32'd0, 11'h002, 11'h000, 11'h000, 11'h001, 11'h001, 34'd0, "d4");
      directed(32'd3, 32'd7, 11'h000, 11'h000, 11'h001, 11'h000, 11'h000, 34'd21, "d3");

      // Back-to-back stream with a 3-cycle downstream stall
      pulse_reset();
      @(posedge CLK); #1;
      out_ready = 1'b1;
      fork
         begin
            int guard;
            logic acc;
            for (int k = 0; k < 4; k++) begin
               in_valid = 1'b1;
               mx       = stall_x[k];
               my_in    = 32'd11 + k;
               guard    = 0;
               acc      = 1'b0;
               while (!acc && guard < 50) begin
                  @(negedge CLK);
                  acc = in_ready;
                  @(posedge CLK); #1;
                  guard++;
               end
               if (!acc) chk("stall_in_accept", 0, 1);
            end
            in_valid = 1'b0;
         end
         begin
            int g;
            g = 0;
            while (!out_valid && g < 20) begin
               @(posedge CLK); #1;
               g++;
            end
            chk("stall_first_valid", out_valid, 1);
            sel_h = {s, d, t, q, n};
            my_h  = my;
            tmy_h = tmy;
            out_ready = 1'b0;
            repeat (3) begin
               @(posedge CLK); #1;
               chk("stall_valid",    out_valid, 1);
               chk("stall_sel",      {9'b0, s, d, t, q, n}, {9'b0, sel_h});
               chk("stall_my",       my, my_h);
               chk("stall_tmy",      tmy, tmy_h);
               chk("stall_in_ready", in_ready, 0);
            end
            out_ready = 1'b1;
         end
      join
      drain("stall_drain");
      chk("stall_op_cnt", op_cnt, 4);

      // Reset with two pairs in flight
      @(posedge CLK); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1; mx = 32'h0000_0099; my_in = 32'd77;
      @(posedge CLK); #1;
      mx = 32'hDEAD_BEEF; my_in = 32'd78;
      @(posedge CLK); #1;
      in_valid = 1'b0;
      chk("flight_valid", out_valid, 1);
      #2;
      RST = 1'b0;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready",  in_ready, 0);
      chk("arst_sel",       {9'b0, s, d, t, q, n}, 0);
      chk("arst_my",        my, 0);
      chk("arst_tmy",       tmy, 0);
      chk("arst_op_cnt",    op_cnt, 0);
      out_ready = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      repeat (6) begin
         @(posedge CLK); #1;
         chk("no_stale", out_valid, 0);
      end

      // Random stream with random backpressure
      n_acc = 0;
      cyc   = 0;
      while (n_acc < 10000 && cyc < 60000) begin
         @(posedge CLK); #1;
         cyc++;
         if (in_fire_s) n_acc++;
         if (!in_valid || in_fire_s) begin
            if (n_acc < 10000) begin
               in_valid = ($urandom_range(0, 9) < 8);
               mx       = pick();
               my_in    = pick();
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = $urandom_range(0, 1) == 1;
      end
      in_valid = 1'b0;
      chk("rand_accepted", n_acc, 10000);
      drain("rand_drain");
      chk("rand_out_cnt", op_cnt, 10000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
